// File: rtl/rv_word_packer.sv
// Packs BYTE_WIDTH input beats into WORD_BYTES-wide words over ready-valid.
// Flush emits a partial word; unfilled lanes are zero and OUT_COUNT_O gives the beat count.
module rv_word_packer #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_BYTES = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                                CLK_I,
  input  logic                                RST_I,
  input  logic                                IN_VALID_I,
  output logic                                IN_READY_O,
  input  logic [BYTE_WIDTH-1:0]               IN_DATA_I,
  input  logic                                FLUSH_I,
  output logic                                OUT_VALID_O,
  input  logic                                OUT_READY_I,
  output logic [WORD_BYTES*BYTE_WIDTH-1:0]    OUT_DATA_O,
  output logic [$clog2(WORD_BYTES+1)-1:0]     OUT_COUNT_O,
  output logic                                BUSY_O
);

  localparam int WW = WORD_BYTES * BYTE_WIDTH;
  localparam int CW = $clog2(WORD_BYTES + 1);

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    FLUSHING
  } state_t;

  logic [WW-1:0] asm_q, asm_d;
  logic [CW-1:0] count_q, count_d, base_cnt;
  logic          flush_pend_q, flush_pend_d;
  logic [WW-1:0] out_q;
  logic [CW-1:0] out_count_q;
  logic          out_valid_q;

  state_t state;
  logic   slot_free;
  logic   xfer;
  logic   in_ready;
  logic   accept;

  always_comb begin
    state = COLLECT;
    if (count_q == CW'(WORD_BYTES)) begin
      state = FULL;
    end else if (flush_pend_q) begin
      state = FLUSHING;
    end

    slot_free = !out_valid_q || OUT_READY_I;
    xfer      = (state != COLLECT) && slot_free;

    // A flush boundary must stay exact, so no beat is taken while flushing.
    case (state)
      COLLECT:  in_ready = 1'b1;
      FULL:     in_ready = xfer;
      default:  in_ready = 1'b0;
    endcase

    accept   = IN_VALID_I && in_ready;
    base_cnt = xfer ? '0 : count_q;
    asm_d    = xfer ? '0 : asm_q;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (accept && (base_cnt == CW'(k))) begin
        asm_d[((MSB_FIRST != 0) ? (WORD_BYTES - 1 - k) : k) * BYTE_WIDTH +: BYTE_WIDTH] = IN_DATA_I;
      end
    end
    count_d = base_cnt + {{(CW-1){1'b0}}, accept};

    // A flush never produces an empty word and adds nothing to a completed one.
    flush_pend_d = (flush_pend_q && !xfer) ||
                   (FLUSH_I && (count_d != '0) && (count_d != CW'(WORD_BYTES)));
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      asm_q        <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
      out_q        <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      if (xfer) begin
        out_q       <= asm_q;
        out_count_q <= count_q;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && OUT_READY_I) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign IN_READY_O  = in_ready;
  assign OUT_VALID_O = out_valid_q;
  assign OUT_DATA_O  = out_q;
  assign OUT_COUNT_O = out_count_q;
  assign BUSY_O      = (count_q != '0) || flush_pend_q || out_valid_q;

endmodule

// File: tb/tb_rv_word_packer.sv
// Directed bench for rv_word_packer; an LSB-first and an MSB-first instance share stimulus.
module tb_rv_word_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready0, out_valid0, busy0;
  logic [31:0] out_data0;
  logic [2:0]  out_count0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_data1;
  logic [2:0]  out_count1;

  int tests;
  int fails;

  rv_word_packer #(.BYTE_WIDTH(8), .WORD_BYTES(4), .MSB_FIRST(0)) u_lsb (
    .CLK_I(clk), .RST_I(rst),
    .IN_VALID_I(in_valid), .IN_READY_O(in_ready0), .IN_DATA_I(in_data),
    .FLUSH_I(flush),
    .OUT_VALID_O(out_valid0), .OUT_READY_I(out_ready),
    .OUT_DATA_O(out_data0), .OUT_COUNT_O(out_count0), .BUSY_O(busy0)
  );

  rv_word_packer #(.BYTE_WIDTH(8), .WORD_BYTES(4), .MSB_FIRST(1)) u_msb (
    .CLK_I(clk), .RST_I(rst),
    .IN_VALID_I(in_valid), .IN_READY_O(in_ready1), .IN_DATA_I(in_data),
    .FLUSH_I(flush),
    .OUT_VALID_O(out_valid1), .OUT_READY_I(out_ready),
    .OUT_DATA_O(out_data1), .OUT_COUNT_O(out_count1), .BUSY_O(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid0); end
    tests++; if (out_data0 !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", out_data0); end
    tests++; if (out_count0 !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", out_count0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy0); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
  endtask

  task automatic test_basic_lsb();
    logic ready_low;
    ready_low = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (i + 1));
      #1;
      if (!in_ready0) ready_low = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    if (!in_ready0) ready_low = 1'b1;
    tick();
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid0); end
    tests++; if (out_data0 !== 32'h44332211) begin fails++; $display("FAIL basic_lsb_data got %h want 44332211", out_data0); end
    tests++; if (out_count0 !== 3'd4) begin fails++; $display("FAIL basic_count got %0d want 4", out_count0); end
    tests++; if (out_data1 !== 32'h11223344) begin fails++; $display("FAIL basic_msb_data got %h want 11223344", out_data1); end
    tests++; if (ready_low !== 1'b0) begin fails++; $display("FAIL basic_ready_low got %b want 0", ready_low); end
    tick();
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL basic_consumed got %b want 0", out_valid0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b want 0", busy0); end
  endtask

  task automatic test_stream_msb();
    logic [31:0] got[$];
    int          at[$];
    logic        ready_low;
    ready_low = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin
        in_valid = 1'b1;
        in_data  = 8'(8'h11 * (i + 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 12 && !in_ready1) ready_low = 1'b1;
      tick();
      if (out_valid1) begin
        got.push_back(out_data1);
        at.push_back(i);
      end
    end
    tests++; if (got.size() !== 3) begin fails++; $display("FAIL stream_words got %0d want 3", got.size()); end
    tests++; if (ready_low !== 1'b0) begin fails++; $display("FAIL stream_ready_low got %b want 0", ready_low); end
    if (got.size() >= 3) begin
      tests++; if (got[0] !== 32'h11223344) begin fails++; $display("FAIL stream_w0 got %h want 11223344", got[0]); end
      tests++; if (got[1] !== 32'h55667788) begin fails++; $display("FAIL stream_w1 got %h want 55667788", got[1]); end
      tests++; if (got[2] !== 32'h99AABBCC) begin fails++; $display("FAIL stream_w2 got %h want 99aabbcc", got[2]); end
      tests++; if (at[0] !== 4) begin fails++; $display("FAIL stream_first_at got %0d want 4", at[0]); end
      tests++; if (at[1] - at[0] !== 4) begin fails++; $display("FAIL stream_gap1 got %0d want 4", at[1] - at[0]); end
      tests++; if (at[2] - at[1] !== 4) begin fails++; $display("FAIL stream_gap2 got %0d want 4", at[2] - at[1]); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_data = 8'hBB; tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL flush_req_ready got %b want 1", in_ready0); end
    tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 8'hDD;
    #1;
    tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL flushing_ready got %b want 0", in_ready0); end
    tick();
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL flush_valid got %b want 1", out_valid0); end
    tests++; if (out_data0 !== 32'h0000BBAA) begin fails++; $display("FAIL flush_data got %h want 0000bbaa", out_data0); end
    tests++; if (out_count0 !== 3'd2) begin fails++; $display("FAIL flush_count got %0d want 2", out_count0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL after_flush_ready got %b want 1", in_ready0); end
    tick();
    in_valid = 1'b0;
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL lane0_busy got %b want 1", busy0); end
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    tests++; if (out_data0 !== 32'h000000DD) begin fails++; $display("FAIL lane0_data got %h want 000000dd", out_data0); end
    tests++; if (out_count0 !== 3'd1) begin fails++; $display("FAIL lane0_count got %0d want 1", out_count0); end
    tick();
  endtask

  task automatic test_flush_coincident();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'hCC; flush = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b0; tick();
    tests++; if (out_data0 !== 32'h00CC0201) begin fails++; $display("FAIL coinc_data got %h want 00cc0201", out_data0); end
    tests++; if (out_count0 !== 3'd3) begin fails++; $display("FAIL coinc_count got %0d want 3", out_count0); end
    tick();
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL coinc_idle got %b want 0", busy0); end
    flush = 1'b1; tick();
    flush = 1'b0;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL empty_flush_busy got %b want 0", busy0); end
    tick();
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL empty_flush_valid got %b want 0", out_valid0); end
  endtask

  task automatic test_backpressure();
    int   n;
    logic acc;
    logic stable_bad;
    n = 0;
    stable_bad = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 16 && n < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(n + 1);
      #1;
      acc = in_ready0;
      tick();
      if (acc) n++;
      if (out_valid0 && out_data0 !== 32'h04030201) stable_bad = 1'b1;
    end
    tests++; if (n !== 8) begin fails++; $display("FAIL bp_accepted got %0d want 8", n); end
    tests++; if (stable_bad !== 1'b0) begin fails++; $display("FAIL bp_held_changed got %b want 0", stable_bad); end
    in_data = 8'h09;
    #1;
    tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", in_ready0); end
    tick(); tick();
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL bp_held_valid got %b want 1", out_valid0); end
    tests++; if (out_data0 !== 32'h04030201) begin fails++; $display("FAIL bp_held_data got %h want 04030201", out_data0); end
    tests++; if (out_count0 !== 3'd4) begin fails++; $display("FAIL bp_held_count got %0d want 4", out_count0); end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL bp_drain_ready got %b want 1", in_ready0); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_data0 !== 32'h08070605) begin fails++; $display("FAIL bp_second_data got %h want 08070605", out_data0); end
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL bp_second_valid got %b want 1", out_valid0); end
    tick();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL bp_drain_byte_busy got %b want 1", busy0); end
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    tests++; if (out_data0 !== 32'h00000009) begin fails++; $display("FAIL bp_drain_byte got %h want 00000009", out_data0); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rst_word_busy got %b want 0", busy0); end
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 5); tick();
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid0 !== 1'b1) begin fails++; $display("FAIL rst_pre_valid got %b want 1", out_valid0); end
    rst = 1'b1;
    #1;
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid0); end
    tests++; if (out_data0 !== 32'h0) begin fails++; $display("FAIL rst_out_data got %h want 0", out_data0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rst_out_busy got %b want 0", busy0); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA1 + i); tick();
      if (out_valid0) stale = 1'b1;
    end
    in_valid = 1'b0;
    tick();
    tests++; if (stale !== 1'b0) begin fails++; $display("FAIL rst_stale_out got %b want 0", stale); end
    tests++; if (out_data0 !== 32'hA4A3A2A1) begin fails++; $display("FAIL rst_clean_data got %h want a4a3a2a1", out_data0); end
    tests++; if (out_count0 !== 3'd4) begin fails++; $display("FAIL rst_clean_count got %0d want 4", out_count0); end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_lsb();
    test_stream_msb();
    test_flush();
    test_flush_coincident();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
